// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: multi-lane serial generator of comma sync, counting data bursts and error commas
module serial_pattern_gen #(
    parameter int LANES = 2,
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] COMMA = 8'hBC,
    parameter int SYNC_COUNT = 4,
    parameter int BURST_LEN = 3,
    parameter int GAP_COMMAS = 1,
    parameter logic [WIDTH-1:0] DATA_START = '1,
    parameter logic [WIDTH-1:0] DATA_STEP = 8'h11
) (
    input  logic             clk_8f,
    input  logic             reset_L,
    input  logic             enable,
    input  logic             mode,
    input  logic             inject_err,
    output logic [LANES-1:0] ser_out,
    output logic             word_start,
    output logic             is_data,
    output logic             burst_done
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = 16;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_COUNT - 1);
    localparam logic [CW-1:0] BURST_LAST = CW'(BURST_LEN - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_COMMAS - 1);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, GAP, ERR} state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dcnt_q, dcnt_d;
    logic             pend_q, pend_d;
    logic [LANES-1:0] ser_q, ser_d;
    logic             ws_q, ws_d;
    logic             isd_q, isd_d;
    logic             bd_q, bd_d;
    logic [WIDTH-1:0] lane_w [LANES];
    logic             last_bit, burst_end;

    assign last_bit  = bit_q == BIT_LAST;
    assign burst_end = (state_q == DATA) && (cnt_q == BURST_LAST);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_w[g] = (state_q == DATA) ? dcnt_q - WIDTH'(g * DATA_STEP) :
                           (state_q == ERR)  ? COMMA ^ WIDTH'(1) : COMMA;
    end

    // Next state: bit/word sequencing, word-boundary decisions and the registered outputs
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        pend_d  = pend_q | inject_err;
        ser_d   = '0;
        ws_d    = 1'b0;
        isd_d   = 1'b0;
        bd_d    = 1'b0;
        if (state_q == IDLE) begin
            state_d = enable ? SYNC : IDLE;
            bit_d   = '0;
            cnt_d   = '0;
        end else begin
            for (int l = 0; l < LANES; l++) ser_d[l] = lane_w[l][BIT_LAST - bit_q];
            ws_d  = bit_q == '0;
            isd_d = state_q == DATA;
            bd_d  = burst_end && last_bit;
            bit_d = last_bit ? '0 : bit_q + BW'(1);
            if (last_bit) begin
                dcnt_d  = (state_q == DATA) ? dcnt_q - DATA_STEP : dcnt_q;
                state_d = !enable          ? IDLE :
                          pend_d           ? ERR  :
                          state_q == SYNC  ? ((cnt_q == SYNC_LAST) ? DATA : SYNC) :
                          state_q == DATA  ? (burst_end ? (mode ? IDLE : GAP) : DATA) :
                          state_q == GAP   ? ((cnt_q == GAP_LAST) ? DATA : GAP) : SYNC;
                pend_d  = enable ? 1'b0 : pend_d;
                cnt_d   = (state_d != state_q) ? '0 : cnt_q + CW'(1);
            end
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_8f) begin
        if (!reset_L) begin
            state_q <= IDLE;
            bit_q   <= '0;
            cnt_q   <= '0;
            dcnt_q  <= DATA_START;
            pend_q  <= 1'b0;
            ser_q   <= '0;
            ws_q    <= 1'b0;
            isd_q   <= 1'b0;
            bd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            pend_q  <= pend_d;
            ser_q   <= ser_d;
            ws_q    <= ws_d;
            isd_q   <= isd_d;
            bd_q    <= bd_d;
        end
    end

    assign ser_out    = ser_q;
    assign word_start = ws_q;
    assign is_data    = isd_q;
    assign burst_done = bd_q;
endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb_serial_pattern_gen: directed check of sync, bursts, gap, error injection, enable drop and reset
module tb_serial_pattern_gen;
    logic       clk_8f = 1'b0;
    logic       reset_L = 1'b0;
    logic       enable = 1'b0;
    logic       mode = 1'b0;
    logic       inject_err = 1'b0;
    logic [1:0] ser_out;
    logic       word_start, is_data, burst_done;
    int         n_tests = 0;
    int         n_fail = 0;

    serial_pattern_gen dut (
        .clk_8f(clk_8f), .reset_L(reset_L), .enable(enable), .mode(mode),
        .inject_err(inject_err), .ser_out(ser_out), .word_start(word_start),
        .is_data(is_data), .burst_done(burst_done)
    );

    always #5 clk_8f = ~clk_8f;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clk_8f);
        check(tag, {28'd0, ser_out, word_start, is_data, burst_done}, 32'd0);
    endtask

    // act: 0 none, 1 pulse inject_err after bit 'at', 2 drop enable after bit 'at'
    task automatic word(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                        input logic eisd, input logic ebd, input int act, input int at);
        logic [7:0] w0, w1, ws, isd, bd;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk_8f);
            w0  = {w0[6:0], ser_out[0]};
            w1  = {w1[6:0], ser_out[1]};
            ws  = {ws[6:0], word_start};
            isd = {isd[6:0], is_data};
            bd  = {bd[6:0], burst_done};
            inject_err = (act == 1) && (b == at);
            if (act == 2 && b == at) enable = 1'b0;
        end
        check({tag, "_lanes"}, {16'd0, w1, w0}, {16'd0, e1, e0});
        check({tag, "_ws"}, {24'd0, ws}, 32'h80);
        check({tag, "_isd"}, {24'd0, isd}, eisd ? 32'hFF : 32'h00);
        check({tag, "_bd"}, {24'd0, bd}, ebd ? 32'h01 : 32'h00);
    endtask

    task automatic sync4(input string tag);
        for (int k = 0; k < 4; k++) word(tag, 8'hBC, 8'hBC, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        enable = 1'b1;
        mode   = 1'b1;
        for (int k = 0; k < 3; k++) check_quiet("reset_hold");
        reset_L = 1'b1;
        check_quiet("start_idle");
        sync4("m1_sync");
        word("m1_d0", 8'hFF, 8'hEE, 1'b1, 1'b0, 0, 0);
        word("m1_d1", 8'hEE, 8'hDD, 1'b1, 1'b0, 0, 0);
        word("m1_d2", 8'hDD, 8'hCC, 1'b1, 1'b1, 0, 0);
        check_quiet("m1_idle_after");

        reset_L = 1'b0;
        mode    = 1'b0;
        @(negedge clk_8f);
        reset_L = 1'b1;
        check_quiet("m0_start_idle");
        sync4("m0_sync");
        word("m0_b1_0", 8'hFF, 8'hEE, 1'b1, 1'b0, 0, 0);
        word("m0_b1_1", 8'hEE, 8'hDD, 1'b1, 1'b0, 0, 0);
        word("m0_b1_2", 8'hDD, 8'hCC, 1'b1, 1'b1, 0, 0);
        word("m0_gap1", 8'hBC, 8'hBC, 1'b0, 1'b0, 0, 0);
        word("m0_b2_0", 8'hCC, 8'hBB, 1'b1, 1'b0, 0, 0);
        word("m0_b2_1", 8'hBB, 8'hAA, 1'b1, 1'b0, 0, 0);
        word("m0_b2_2", 8'hAA, 8'h99, 1'b1, 1'b1, 0, 0);
        word("m0_gap2", 8'hBC, 8'hBC, 1'b0, 1'b0, 0, 0);

        word("err_pre", 8'h99, 8'h88, 1'b1, 1'b0, 1, 2);
        word("err_word", 8'hBD, 8'hBD, 1'b0, 1'b0, 0, 0);
        sync4("err_sync");
        word("err_d0", 8'h88, 8'h77, 1'b1, 1'b0, 0, 0);
        word("err_d1", 8'h77, 8'h66, 1'b1, 1'b0, 0, 0);
        word("err_d2", 8'h66, 8'h55, 1'b1, 1'b1, 0, 0);
        word("err_gap", 8'hBC, 8'hBC, 1'b0, 1'b0, 0, 0);

        word("dis_word", 8'h55, 8'h44, 1'b1, 1'b0, 2, 3);
        for (int k = 0; k < 3; k++) check_quiet("dis_idle");
        enable = 1'b1;
        check_quiet("dis_restart_idle");
        sync4("dis_sync");
        word("dis_d0", 8'h44, 8'h33, 1'b1, 1'b0, 0, 0);
        word("dis_d1", 8'h33, 8'h22, 1'b1, 1'b0, 0, 0);
        word("dis_d2", 8'h22, 8'h11, 1'b1, 1'b1, 0, 0);
        word("dis_gap", 8'hBC, 8'hBC, 1'b0, 1'b0, 0, 0);

        for (int b = 0; b < 5; b++) @(negedge clk_8f);
        check("rst_mid_isd", {31'd0, is_data}, 32'd1);
        reset_L = 1'b0;
        check_quiet("rst_mid_quiet");
        reset_L = 1'b1;
        check_quiet("rst_restart_idle");
        sync4("rst_sync");
        word("rst_d0", 8'hFF, 8'hEE, 1'b1, 1'b0, 0, 0);
        word("rst_d1", 8'hEE, 8'hDD, 1'b1, 1'b0, 0, 0);
        mode = 1'b1;
        word("end_err_d2", 8'hDD, 8'hCC, 1'b1, 1'b1, 1, 2);
        word("end_err_word", 8'hBD, 8'hBD, 1'b0, 1'b0, 0, 0);
        sync4("end_err_sync");
        word("end_err_data", 8'hCC, 8'hBB, 1'b1, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
